// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and constants for the LFSR and its bounded-random consumers
package lfsr_pkg;

  localparam int LFSR_WIDTH = 32;

  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 32'hACE1_5EED;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    HOLD
  } sampler_state_e;

endpackage

// File: rtl/lfsr_range_sampler_if.sv
// lfsr_range_sampler_if: request/response handshake between a requester and the range sampler
interface lfsr_range_sampler_if #(
  parameter int W = 8
) ();

  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_bound;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_value;

  modport master (
    output req_valid, req_bound, rsp_ready,
    input  req_ready, rsp_valid, rsp_value
  );

  modport slave (
    input  req_valid, req_bound, rsp_ready,
    output req_ready, rsp_valid, rsp_value
  );

endinterface

// File: rtl/lfsr_mask_gen.sv
// lfsr_mask_gen: smears N-1 into the smallest all-ones mask 2^k-1 that covers it
module lfsr_mask_gen #(
  parameter int W = 8
) (
  input  logic [W-1:0] bound_i,
  output logic [W-1:0] mask_o
);

  logic [W-1:0] nm1;

  assign nm1 = bound_i - W'(1);

  for (genvar i = 0; i < W; i++) begin : g_smear
    assign mask_o[i] = |nm1[W-1:i];
  end

endmodule

// File: rtl/lfsr_range_sampler.sv
// lfsr_range_sampler: rejection-sampled uniform value in [0, N) from the LFSR state; define LFSR_SAMPLER_STATS_EN to count rejections on reject_cnt_o
module lfsr_range_sampler
  import lfsr_pkg::*;
#(
  parameter int W         = 8,
  parameter int MAX_TRIES = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [LFSR_WIDTH-1:0] lfsr_state_i,
  lfsr_range_sampler_if.slave   bus,
  output logic [15:0]           reject_cnt_o
);

  localparam logic [7:0] LAST_TRY = 8'(MAX_TRIES - 1);

  sampler_state_e state_q, state_d;
  logic [W-1:0]   bound_q, bound_d;
  logic [W-1:0]   mask_q, mask_d;
  logic [W-1:0]   value_q, value_d;
  logic [W-1:0]   new_mask, cand;
  logic [7:0]     tries_q, tries_d;
  logic           rsp_valid_q;
  logic           reject;
  logic           unused_lfsr;

  assign unused_lfsr   = ^lfsr_state_i[LFSR_WIDTH-1:W];
  assign bus.req_ready = reset_ni && state_q == IDLE;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_value = value_q;
  assign cand          = lfsr_state_i[W-1:0] & mask_q;

  lfsr_mask_gen #(.W(W)) u_mask_gen (
    .bound_i (bus.req_bound),
    .mask_o  (new_mask)
  );

  // next state: accept in IDLE, draw masked candidates in SAMPLE, present the result in HOLD
  always_comb begin
    state_d = state_q;
    bound_d = bound_q;
    mask_d  = mask_q;
    value_d = value_q;
    tries_d = tries_q;
    reject  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          bound_d = bus.req_bound;
          mask_d  = new_mask;
          value_d = '0;
          tries_d = '0;
          state_d = bus.req_bound <= W'(1) ? HOLD : SAMPLE;
        end
      end
      SAMPLE: begin
        reject  = cand >= bound_q;
        value_d = reject ? cand - bound_q : cand;
        state_d = (!reject || tries_q == LAST_TRY) ? HOLD : SAMPLE;
        tries_d = tries_q + 8'd1;
      end
      HOLD: state_d = bus.rsp_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers; reset abandons any in-flight request
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      bound_q     <= '0;
      mask_q      <= '0;
      value_q     <= '0;
      tries_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bound_q     <= bound_d;
      mask_q      <= mask_d;
      value_q     <= value_d;
      tries_q     <= tries_d;
      rsp_valid_q <= state_d == HOLD;
    end
  end

`ifdef LFSR_SAMPLER_STATS_EN
  // saturating count of rejected candidates, fallback cycle included
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) reject_cnt_o <= '0;
    else if (reject && reject_cnt_o != 16'hFFFF) reject_cnt_o <= reject_cnt_o + 16'd1;
  end
`else
  logic unused_reject;
  assign unused_reject = reject;
  assign reject_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_lfsr_range_sampler.sv
// tb_lfsr_range_sampler: scoreboard bench for the range sampler, directed cases plus LFSR-driven random requests
module tb_lfsr_range_sampler;
  import lfsr_pkg::*;

  localparam int W         = 8;
  localparam int MAX_TRIES = 8;
`ifdef LFSR_SAMPLER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    int n;
    int value;
    int lat;
    int rej;
    int c0;
    int cum;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic [31:0] lfsr_reg = LFSR_SEED;
  logic [31:0] dir_v = '0;
  logic        use_dir = 1'b0;
  logic [31:0] lfsr_state;
  logic [15:0] reject_cnt;
  logic [31:0] dir_q[$];
  exp_t        exp_q[$];
  exp_t        cur;
  int          vec = 0;
  int          miss = 0;
  int          cyc = 0;
  int          cum = 0;
  int          last_val = -1;
  int          last_lat = -1;
  bit          pv = 1'b0;

  lfsr_range_sampler_if #(.W(W)) bus ();

  lfsr_range_sampler #(.W(W), .MAX_TRIES(MAX_TRIES)) dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .lfsr_state_i (lfsr_state),
    .bus          (bus),
    .reject_cnt_o (reject_cnt)
  );

  always #5 clk_i = ~clk_i;

  assign lfsr_state = use_dir ? dir_v : lfsr_reg;

  function automatic logic [31:0] step8(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'h8020_0003 : r >> 1;
    return r;
  endfunction

  function automatic logic [31:0] dv(input logic [7:0] b);
    logic [31:0] r;
    r = $urandom;
    return {r[31:8], b};
  endfunction

  function automatic exp_t predict(input int n, input int s[$]);
    exp_t e;
    int   m;
    e = '{n: n, value: 0, lat: 1, rej: 0, c0: 0, cum: 0};
    if (n <= 1) return e;
    m = 0;
    while (m < n - 1) m = 2 * m + 1;
    for (int t = 0; t < MAX_TRIES; t++) begin
      int c;
      c = s[t] & m;
      if (c < n) begin
        e.value = c;
        e.lat   = 2 + t;
        return e;
      end
      e.rej++;
      e.value = c - n;
      e.lat   = 1 + MAX_TRIES;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int want);
    vec++;
    if (act != want) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  always @(posedge clk_i) begin
    cyc++;
    lfsr_reg <= step8(lfsr_reg);
    if (dir_q.size() > 0) dir_v <= dir_q.pop_front();
  end

  always @(negedge clk_i) begin
    if (!reset_ni) pv = 1'b0;
    else begin
      if (bus.rsp_valid && !pv) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          cur = exp_q.pop_front();
          last_val = int'(bus.rsp_value);
          last_lat = cyc - cur.c0;
          chk("value", last_val, cur.value);
          chk("latency", last_lat, cur.lat);
          chk("reject_cnt", int'(reject_cnt), STATS ? cur.cum : 0);
          chk("in_range", int'(cur.n <= 1 ? last_val == 0 : last_val < cur.n), 1);
        end
      end else if (bus.rsp_valid) begin
        chk("hold_stable", int'(bus.rsp_value), cur.value);
        chk("hold_req_ready", int'(bus.req_ready), 0);
      end
      pv = bus.rsp_valid;
    end
  end

  task automatic req(input int n, input int hold, input logic [31:0] seq[$]);
    exp_t e;
    int   s[$];
    int   k;
    logic [31:0] r;
    @(negedge clk_i);
    k = 0;
    while (!bus.req_ready && k < 64) begin
      @(negedge clk_i);
      k++;
    end
    if (!bus.req_ready) begin
      chk("req_ready_timeout", 0, 1);
      return;
    end
    if (seq.size() > 0) begin
      use_dir = 1'b1;
      dir_q = seq;
      for (int t = 0; t < MAX_TRIES; t++) begin
        r = seq[t < seq.size() ? t : seq.size() - 1];
        s.push_back(int'(r[W-1:0]));
      end
    end else begin
      use_dir = 1'b0;
      r = lfsr_reg;
      for (int t = 0; t < MAX_TRIES; t++) begin
        r = step8(r);
        s.push_back(int'(r[W-1:0]));
      end
    end
    e = predict(n, s);
    e.c0 = cyc;
    cum = cum + e.rej > 65535 ? 65535 : cum + e.rej;
    e.cum = cum;
    exp_q.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_bound = W'(n);
    @(negedge clk_i);
    bus.req_valid = 1'b0;
    bus.req_bound = W'($urandom);
    k = 0;
    while (!bus.rsp_valid && k < MAX_TRIES + 4) begin
      @(negedge clk_i);
      k++;
    end
    if (!bus.rsp_valid) begin
      chk("rsp_timeout", 0, 1);
      exp_q.delete();
      return;
    end
    repeat (hold) @(negedge clk_i);
    bus.rsp_ready = 1'b1;
    @(negedge clk_i);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] none[$];
    int          hist[6];
    real         chi2;
    bus.req_valid = 1'b0;
    bus.req_bound = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("reset_req_ready", int'(bus.req_ready), 0);
    chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
    chk("reset_rsp_value", int'(bus.rsp_value), 0);
    chk("reset_reject_cnt", int'(reject_cnt), 0);
    reset_ni = 1'b1;
    @(negedge clk_i);
    chk("idle_req_ready", int'(bus.req_ready), 1);

    q = {dv(8'h07)};
    req(10, 0, q);
    chk("n10_accept_value", last_val, 7);
    chk("n10_accept_latency", last_lat, 2);
    q = {dv(8'h0C), dv(8'h0F), dv(8'h03)};
    req(10, 1, q);
    chk("n10_two_reject_value", last_val, 3);
    chk("n10_two_reject_latency", last_lat, 4);
    q = {dv(8'h0E)};
    req(10, 0, q);
    chk("n10_fallback_value", last_val, 4);
    chk("n10_fallback_latency", last_lat, 9);
    q = {dv(8'h5A)};
    req(0, 5, q);
    chk("n0_value", last_val, 0);
    chk("n0_latency", last_lat, 1);
    q = {dv(8'hFF)};
    req(1, 5, q);
    chk("n1_value", last_val, 0);
    chk("n1_latency", last_lat, 1);
    q = {dv(8'hFF), dv(8'hFE)};
    req(255, 2, q);
    chk("n255_reject_then_254", last_val, 254);
    q = {dv(8'hFF)};
    req(255, 0, q);
    chk("n255_fallback", last_val, 0);
    q = {dv(8'h03)};
    req(2, 0, q);
    chk("n2_mask1", last_val, 1);
    q = {dv(8'hFF)};
    req(128, 0, q);
    chk("n128_mask127", last_val, 127);

    q = {dv(8'h0E)};
    @(negedge clk_i);
    use_dir = 1'b1;
    dir_q = q;
    bus.req_valid = 1'b1;
    bus.req_bound = 8'd10;
    @(negedge clk_i);
    bus.req_valid = 1'b0;
    @(negedge clk_i);
    #2 reset_ni = 1'b0;
    #1;
    chk("async_reset_rsp_valid", int'(bus.rsp_valid), 0);
    chk("async_reset_rsp_value", int'(bus.rsp_value), 0);
    chk("async_reset_req_ready", int'(bus.req_ready), 0);
    chk("async_reset_reject_cnt", int'(reject_cnt), 0);
    cum = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);
    chk("post_reset_idle", int'(bus.req_ready), 1);
    q = {dv(8'h64)};
    req(200, 0, q);
    chk("n200_after_reset", last_val, 100);
    chk("n200_after_reset_latency", last_lat, 2);

    for (int i = 0; i < 3000; i++) req($urandom_range(0, 255), $urandom_range(0, 3), none);
    for (int i = 0; i < 6; i++) hist[i] = 0;
    for (int i = 0; i < 1200; i++) begin
      req(6, $urandom_range(0, 2), none);
      if (last_val >= 0 && last_val < 6) hist[last_val]++;
    end
    chi2 = 0.0;
    for (int i = 0; i < 6; i++) chi2 += (real'(hist[i]) - 200.0) ** 2 / 200.0;
    chk("chi2_n6_x1000", int'(chi2 < 20.52), 1);
    repeat (4) @(negedge clk_i);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
